// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and constants for the register-file write-back path.
//   DW       data width
//   REG_AW   register-number width
//   REG_ZERO hard-wired zero register number
//   NREGS    number of architectural registers
package mips_pkg;

  localparam int DW     = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One-hot mask for a register number; used to set/clear pend bits.
  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_AW-1:0] rn);
    reg_mask = NREGS'(1) << rn;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous in-order FIFO holding long-latency results.
// Ports:
//   clk, clrn        clock (rising edge), asynchronous active-low reset
//   push, din        enqueue din when push and not full
//   pop, dout        dequeue head when pop and not empty; dout shows head
//   full, empty      registered occupancy flags
//   count            occupancy, 0..DEPTH
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_writer.sv
// wb_writer: write-back stage driving the register file's single write port.
// ALU results (never stalled) take priority; long-latency results queue in
// wb_fifo and drain whenever the ALU leaves the port free. A pending bitmap
// tracks registers whose long-latency result has not yet been written.
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   alu_we/alu_wn/alu_d       single-cycle ALU result
//   lng_valid/lng_ready       long-result handshake (ready = FIFO not full)
//   lng_wn/lng_d              long-result destination and data
//   iss_valid/iss_rd          long op issue, marks iss_rd pending
//   pend                      pending-destination bitmap (bit 0 always 0)
//   q_cnt                     FIFO occupancy
//   we/wn/d                   registered register-file write port
// Optional build macro WB_BYPASS_EN adds byp_rn/byp_hit/byp_d forwarding of
// the value being written this cycle, and a check that the ALU never writes
// a pending register.
module wb_writer
  import mips_pkg::*;
#(
  parameter int DW     = mips_pkg::DW,
  parameter int AW     = mips_pkg::REG_AW,
  parameter int QDEPTH = 4,
  localparam int CW    = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_wn,
  input  logic [DW-1:0] alu_d,
  input  logic          lng_valid,
  output logic          lng_ready,
  input  logic [AW-1:0] lng_wn,
  input  logic [DW-1:0] lng_d,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0] byp_rn,
  output logic          byp_hit,
  output logic [DW-1:0] byp_d,
`endif
  output logic [NREGS-1:0] pend,
  output logic [CW-1:0] q_cnt,
  output logic          we,
  output logic [AW-1:0] wn,
  output logic [DW-1:0] d
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic              alu_sel;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW+DW-1:0]  fifo_dout;
  logic [AW-1:0]     head_wn;
  logic [DW-1:0]     head_d;
  logic [NREGS-1:0]  pend_nxt;

  // Writes to r0 are dropped: alu_wn==0 frees the port for a FIFO pop, and
  // lng_wn==0 is handshaken but never stored.
  assign alu_sel   = alu_we && (alu_wn != ZERO);
  assign lng_ready = !fifo_full;
  assign fifo_push = lng_valid && lng_ready && (lng_wn != ZERO);
  assign fifo_pop  = !alu_sel && !fifo_empty;
  assign head_wn   = fifo_dout[AW+DW-1:DW];
  assign head_d    = fifo_dout[DW-1:0];

  wb_fifo #(
    .W     (AW + DW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (fifo_push),
    .din   ({lng_wn, lng_d}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_cnt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we <= 1'b0;
      wn <= '0;
      d  <= '0;
    end else begin
      we <= alu_sel || fifo_pop;
      if (alu_sel) begin
        wn <= alu_wn;
        d  <= alu_d;
      end else if (fifo_pop) begin
        wn <= head_wn;
        d  <= head_d;
      end
    end
  end

  // Clear on FIFO-sourced write first so a same-edge issue to that register wins.
  always_comb begin
    pend_nxt = pend;
    if (fifo_pop) begin
      pend_nxt = pend_nxt & ~reg_mask(REG_AW'(head_wn));
    end
    if (iss_valid && (iss_rd != ZERO)) begin
      pend_nxt = pend_nxt | reg_mask(REG_AW'(iss_rd));
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value being written while the register file still holds the old one.
  assign byp_hit = we && (wn == byp_rn) && (byp_rn != ZERO);
  assign byp_d   = d;

  a_no_alu_to_pending : assert property (
    @(posedge clk) disable iff (!clrn)
    !(alu_we && (alu_wn != ZERO) && pend[alu_wn])
  );
`endif

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed bench for wb_writer with a queue-based reference model.
module tb_wb_writer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clrn;
  logic          alu_we;
  logic [AW-1:0] alu_wn;
  logic [DW-1:0] alu_d;
  logic          lng_valid;
  logic          lng_ready;
  logic [AW-1:0] lng_wn;
  logic [DW-1:0] lng_d;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [31:0]   pend;
  logic [CW-1:0] q_cnt;
  logic          we;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] byp_rn;
  logic          byp_hit;
  logic [DW-1:0] byp_d;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  wb_writer #(.DW(DW), .AW(AW), .QDEPTH(QD)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .alu_we    (alu_we),
    .alu_wn    (alu_wn),
    .alu_d     (alu_d),
    .lng_valid (lng_valid),
    .lng_ready (lng_ready),
    .lng_wn    (lng_wn),
    .lng_d     (lng_d),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
`ifdef WB_BYPASS_EN
    .byp_rn    (byp_rn),
    .byp_hit   (byp_hit),
    .byp_d     (byp_d),
`endif
    .pend      (pend),
    .q_cnt     (q_cnt),
    .we        (we),
    .wn        (wn),
    .d         (d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of long results and a pending bit set.
  typedef struct {
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_wn   = '0;
  logic [31:0] m_d    = '0;
  logic [31:0] m_pend = '0;

  initial forever begin
    @(posedge clk or negedge clrn);
    if (!clrn) begin
      mq.delete();
      m_we   = 1'b0;
      m_wn   = '0;
      m_d    = '0;
      m_pend = '0;
    end else begin
      bit   rdy;
      ent_t e;
      rdy = (mq.size() < QD);
      if (alu_we && alu_wn != 0) begin
        m_we = 1'b1;
        m_wn = alu_wn;
        m_d  = alu_d;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1;
        m_wn = e.wn;
        m_d  = e.d;
        m_pend[e.wn] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (lng_valid && rdy && lng_wn != 0) begin
        e.wn = lng_wn;
        e.d  = lng_d;
        mq.push_back(e);
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_we", 32'(we), 32'(m_we));
      chk("m_wn", 32'(wn), 32'(m_wn));
      chk("m_d", d, m_d);
      chk("m_pend", pend, m_pend);
      chk("m_qcnt", 32'(q_cnt), 32'(mq.size()));
      chk("m_ready", 32'(lng_ready), 32'(mq.size() < QD));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_we    = 1'b0;
    alu_wn    = '0;
    alu_d     = '0;
    lng_valid = 1'b0;
    lng_wn    = '0;
    lng_d     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  initial begin
    idle();
    clrn = 1'b0;
`ifdef WB_BYPASS_EN
    byp_rn = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_ready", 32'(lng_ready), 1);
    clrn   = 1'b1;
    cmp_en = 1'b1;
    step();

    // ALU write appears one cycle later, then the port goes idle.
    alu_we = 1'b1; alu_wn = 5'd3; alu_d = 32'h1234;
    step();
    idle();
    chk("t2_we", 32'(we), 1);
    chk("t2_wn", 32'(wn), 3);
    chk("t2_d", d, 32'h1234);
`ifdef WB_BYPASS_EN
    byp_rn = 5'd3;
    #1;
    chk("byp_hit", 32'(byp_hit), 1);
    chk("byp_d", byp_d, 32'h1234);
    byp_rn = 5'd0;
    #1;
    chk("byp_hit0", 32'(byp_hit), 0);
`endif
    step();
    chk("t2_we_off", 32'(we), 0);
    chk("t2_wn_hold", 32'(wn), 3);

    // ALU beats the queued long result; long result follows and clears pend.
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    idle();
    chk("t3_pend_set", pend, 32'h20);
    lng_valid = 1'b1; lng_wn = 5'd5; lng_d = 32'hAA;
    alu_we = 1'b1; alu_wn = 5'd6; alu_d = 32'h66;
    step();
    idle();
    chk("t3_alu_wn", 32'(wn), 6);
    chk("t3_alu_d", d, 32'h66);
    chk("t3_qcnt", 32'(q_cnt), 1);
    step();
    chk("t3_lng_we", 32'(we), 1);
    chk("t3_lng_wn", 32'(wn), 5);
    chk("t3_lng_d", d, 32'hAA);
    chk("t3_pend_clr", pend, 0);
    step();

    // Fill the FIFO while the ALU owns the port, then drain in order.
    for (int i = 0; i < 4; i++) begin
      alu_we = 1'b1; alu_wn = AW'(10 + i); alu_d = 32'(i);
      lng_valid = 1'b1; lng_wn = AW'(20 + i); lng_d = 32'hB0 + 32'(i);
      step();
    end
    chk("t4_full_ready", 32'(lng_ready), 0);
    chk("t4_full_cnt", 32'(q_cnt), 4);
    alu_wn = 5'd14; lng_wn = 5'd24; lng_d = 32'hB4;
    step();
    chk("t4_reject_cnt", 32'(q_cnt), 4);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_drain_wn", 32'(wn), 20 + i);
      chk("t4_drain_d", d, 32'hB0 + 32'(i));
      chk("t4_drain_cnt", 32'(q_cnt), 3 - i);
    end
    lng_valid = 1'b1; lng_wn = 5'd24; lng_d = 32'hB4;
    step();
    idle();
    step();
    chk("t4_fifth_wn", 32'(wn), 24);
    chk("t4_fifth_d", d, 32'hB4);

    // Register zero is never written, queued, or marked pending.
    alu_we = 1'b1; alu_wn = 5'd0; alu_d = 32'hDEAD;
    lng_valid = 1'b1; lng_wn = 5'd0; lng_d = 32'hBEEF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    chk("t5_ready", 32'(lng_ready), 1);
    step();
    idle();
    chk("t5_we", 32'(we), 0);
    chk("t5_qcnt", 32'(q_cnt), 0);
    chk("t5_pend", pend, 0);

    // Asynchronous reset in the middle of activity discards everything.
    iss_valid = 1'b1; iss_rd = 5'd7;
    alu_we = 1'b1; alu_wn = 5'd11; alu_d = 32'h11;
    lng_valid = 1'b1; lng_wn = 5'd25; lng_d = 32'hC0;
    step();
    iss_valid = 1'b0;
    lng_wn = 5'd26; lng_d = 32'hC1;
    step();
    lng_valid = 1'b0;
    chk("t1_qcnt_pre", 32'(q_cnt), 2);
    chk("t1_pend_pre", pend, 32'h80);
    #1 clrn = 1'b0;
    #1;
    chk("t1_we", 32'(we), 0);
    chk("t1_wn", 32'(wn), 0);
    chk("t1_d", d, 0);
    chk("t1_qcnt", 32'(q_cnt), 0);
    chk("t1_pend", pend, 0);
    chk("t1_ready", 32'(lng_ready), 1);
    idle();
    #1 clrn = 1'b1;
    step();
    chk("t1_after_we", 32'(we), 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
